// File: rtl/eth_tx_arbiter_pkg.sv
// rtl/eth_tx_arbiter_pkg.sv - shared constants and helpers for the RMII transmit arbiter
//
// Purpose: byte/dibit constants, CRC-32 constants, encoded FSM states and a
//          bit-reflection helper shared by eth_tx_arbiter and crc32_dibit.
// Ports:   none (package).
package eth_tx_arbiter_pkg;

   localparam int          BYTE_LEN            = 8;
   localparam logic [1:0]  RMII_PREAMBLE_DIBIT = 2'b01;
   localparam logic [1:0]  RMII_SFD_DIBIT      = 2'b11;
   localparam logic [31:0] ETH_CRC_POLY        = 32'h04C11DB7;
   localparam logic [31:0] ETH_CRC_INIT        = 32'hFFFFFFFF;

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] PREAMBLE = 3'd1;
   localparam logic [2:0] PAYLOAD  = 3'd2;
   localparam logic [2:0] FCS      = 3'd3;
   localparam logic [2:0] IFG      = 3'd4;

   // Ethernet sends bits LSB-first, so the serial CRC runs on the mirrored polynomial.
   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

endpackage

// File: rtl/eth_tx_arbiter_crc32_dibit.sv
// rtl/eth_tx_arbiter_crc32_dibit.sv - two-bit-per-cycle reflected CRC-32 accumulator
//
// Purpose: running Ethernet CRC-32 over RMII dibits, dibit[0] folded in first.
//          Only built when ETH_TX_ARB_FCS_EN is defined.
// Ports:   clk, reset (sync, active-low), clear (reload init), enable (fold dibit),
//          dibit [1:0] input, crc [31:0] raw register (not inverted).
`ifdef ETH_TX_ARB_FCS_EN
module crc32_dibit
   import eth_tx_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        enable,
   input  logic [1:0]  dibit,
   output logic [31:0] crc
);

   localparam logic [31:0] POLY_R = reflect32(ETH_CRC_POLY);

   logic [31:0] step1;
   logic [31:0] step2;

   always_comb begin
      step1 = (crc   >> 1) ^ (((crc[0]   ^ dibit[0]) != 1'b0) ? POLY_R : 32'h0);
      step2 = (step1 >> 1) ^ (((step1[0] ^ dibit[1]) != 1'b0) ? POLY_R : 32'h0);
   end

   always_ff @(posedge clk) begin
      if (!reset || clear) crc <= ETH_CRC_INIT;
      else if (enable)     crc <= step2;
   end

endmodule
`endif

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - round-robin RMII transmit arbiter and dibit serialiser
//
// Purpose: grants the RMII TX path to one of NUM_REQ byte sources per frame
//          (round-robin), sends preamble/SFD, serialises bytes LSB-first as
//          dibits, aborts on source underflow and enforces the inter-frame gap.
//          Define ETH_TX_ARB_FCS_EN to append a generated CRC-32 FCS.
// Ports:   clk, reset (sync, active-low)
//          req/in_data/in_valid/in_last  per-requester frame request and byte stream
//          in_ready  one-cycle consume strobe on the granted index
//          grant     one-hot owner, txen/txd RMII transmit, busy (not IDLE),
//          underflow one-cycle abort pulse
module eth_tx_arbiter
   import eth_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ         = 2,
   parameter int PREAMBLE_DIBITS = 32,
   parameter int IFG_CYCLES      = 48
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*BYTE_LEN-1:0] in_data,
   input  logic [NUM_REQ-1:0]          in_valid,
   input  logic [NUM_REQ-1:0]          in_last,
   output logic [NUM_REQ-1:0]          in_ready,
   output logic [NUM_REQ-1:0]          grant,
   output logic                        txen,
   output logic [1:0]                  txd,
   output logic                        busy,
   output logic                        underflow
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = 16;

   logic [2:0]          state;
   logic [IDX_W-1:0]    ptr;
   logic [IDX_W-1:0]    gidx;
   logic [CNT_W-1:0]    cnt;
   logic [1:0]          dcnt;
   logic [BYTE_LEN-1:0] shift;
   logic                last_byte;

   logic                arb_hit;
   logic [IDX_W-1:0]    arb_idx;
   logic [IDX_W-1:0]    ptr_next;
   logic                fetch_slot;
   logic                src_valid;
   logic                src_last;
   logic [BYTE_LEN-1:0] src_data;

   // First pending requester at or above the pointer, wrapping around.
   always_comb begin
      arb_hit = 1'b0;
      arb_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!arb_hit && req[(int'(ptr) + k) % NUM_REQ]) begin
            arb_hit = 1'b1;
            arb_idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
         end
      end
      ptr_next = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + IDX_W'(1);
   end

   assign src_valid = in_valid[gidx];
   assign src_last  = in_last[gidx];
   assign src_data  = in_data[int'(gidx)*BYTE_LEN +: BYTE_LEN];

   // A byte is pulled on the SFD cycle and on the last dibit of every non-final byte,
   // so consecutive bytes go out back to back.
   assign fetch_slot = ((state == PREAMBLE) && (cnt == CNT_W'(PREAMBLE_DIBITS - 1))) ||
                       ((state == PAYLOAD) && (dcnt == 2'd3) && !last_byte);

   assign in_ready  = (fetch_slot && src_valid) ? grant : '0;
   assign underflow = fetch_slot && !src_valid;
   assign busy      = (state != IDLE);
   assign txen      = (state == PREAMBLE) || (state == PAYLOAD) || (state == FCS);

`ifdef ETH_TX_ARB_FCS_EN
   logic [31:0] crc_q;

   crc32_dibit u_crc (
      .clk    (clk),
      .reset  (reset),
      .clear  (state == PREAMBLE),
      .enable (state == PAYLOAD),
      .dibit  (shift[1:0]),
      .crc    (crc_q)
   );
`endif

   always_comb begin
      txd = 2'b00;
      case (state)
         PREAMBLE: txd = (cnt == CNT_W'(PREAMBLE_DIBITS - 1)) ? RMII_SFD_DIBIT : RMII_PREAMBLE_DIBIT;
         PAYLOAD:  txd = shift[1:0];
`ifdef ETH_TX_ARB_FCS_EN
         // Final inversion applied on the way out; register holds the raw remainder.
         FCS:      txd = ~crc_q[{cnt[3:0], 1'b0} +: 2];
`endif
         default:  txd = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         ptr       <= '0;
         gidx      <= '0;
         grant     <= '0;
         cnt       <= '0;
         dcnt      <= '0;
         shift     <= '0;
         last_byte <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_hit) begin
                  state <= PREAMBLE;
                  gidx  <= arb_idx;
                  grant <= NUM_REQ'(1) << arb_idx;
                  ptr   <= ptr_next;
                  cnt   <= '0;
               end
            end
            PREAMBLE: begin
               if (fetch_slot) begin
                  cnt <= '0;
                  if (src_valid) begin
                     shift     <= src_data;
                     last_byte <= src_last;
                     dcnt      <= 2'd0;
                     state     <= PAYLOAD;
                  end else begin
                     grant <= '0;
                     state <= IFG;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            PAYLOAD: begin
               dcnt  <= dcnt + 2'd1;
               shift <= shift >> 2;
               if (dcnt == 2'd3) begin
                  if (last_byte) begin
                     grant <= '0;
                     cnt   <= '0;
`ifdef ETH_TX_ARB_FCS_EN
                     state <= FCS;
`else
                     state <= IFG;
`endif
                  end else if (src_valid) begin
                     shift     <= src_data;
                     last_byte <= src_last;
                  end else begin
                     grant <= '0;
                     cnt   <= '0;
                     state <= IFG;
                  end
               end
            end
`ifdef ETH_TX_ARB_FCS_EN
            FCS: begin
               if (cnt == CNT_W'(15)) begin
                  cnt   <= '0;
                  state <= IFG;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
`endif
            IFG: begin
               if (cnt == CNT_W'(IFG_CYCLES - 1)) state <= IDLE;
               else                               cnt   <= cnt + CNT_W'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb/tb_eth_tx_arbiter.sv - directed self-checking bench for eth_tx_arbiter
module tb_eth_tx_arbiter;

   logic        clk      = 1'b0;
   logic        reset    = 1'b0;
   logic [1:0]  req      = '0;
   logic [15:0] in_data  = '0;
   logic [1:0]  in_valid = '0;
   logic [1:0]  in_last  = '0;
   logic [1:0]  in_ready;
   logic [1:0]  grant;
   logic        txen;
   logic [1:0]  txd;
   logic        busy;
   logic        underflow;

   eth_tx_arbiter #(
      .NUM_REQ         (2),
      .PREAMBLE_DIBITS (32),
      .IFG_CYCLES      (48)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .grant     (grant),
      .txen      (txen),
      .txd       (txd),
      .busy      (busy),
      .underflow (underflow)
   );

   always #10 clk = ~clk;

   int         n_cmp = 0;
   int         n_fail = 0;
   int         cyc = 0;
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [1:0] hold = '0;

   logic       l_txen  [0:1023];
   logic [1:0] l_txd   [0:1023];
   logic [1:0] l_grant [0:1023];
   logic [1:0] l_rdy   [0:1023];
   logic       l_uf    [0:1023];
   logic       l_busy  [0:1023];

   logic [1:0] pay_exp [0:7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00};
   logic [1:0] a5_exp  [0:3] = '{2'b01, 2'b01, 2'b10, 2'b10};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
      return (c >> 1) ^ ((c[0] ^ b) ? 32'hEDB88320 : 32'h0);
   endfunction

   task automatic drive_src();
      in_valid = '0;
      in_last  = '0;
      in_data  = '0;
      if (q0.size() > 0 && !hold[0]) begin
         in_valid[0]   = 1'b1;
         in_data[7:0]  = q0[0][7:0];
         in_last[0]    = q0[0][8];
      end
      if (q1.size() > 0 && !hold[1]) begin
         in_valid[1]   = 1'b1;
         in_data[15:8] = q1[0][7:0];
         in_last[1]    = q1[0][8];
      end
      req[0] = (q0.size() > 0);
      req[1] = (q1.size() > 0);
   endtask

   task automatic tick();
      logic [1:0] rdy;
      @(negedge clk);
      if (cyc < 1024) begin
         l_txen[cyc]  = txen;
         l_txd[cyc]   = txd;
         l_grant[cyc] = grant;
         l_rdy[cyc]   = in_ready;
         l_uf[cyc]    = underflow;
         l_busy[cyc]  = busy;
      end
      rdy = in_ready;
      cyc++;
      @(posedge clk);
      #1;
      if (rdy[0] && q0.size() > 0) void'(q0.pop_front());
      if (rdy[1] && q1.size() > 0) void'(q1.pop_front());
      drive_src();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int          lows;
      logic [31:0] c;
      logic [31:0] fcs;

      // Reset held with a request pending: reset must dominate.
      q0.push_back(9'h0AA);
      q0.push_back(9'h10F);
      drive_src();
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_txen",      32'(txen),      32'h0);
      chk("rst_txd",       32'(txd),       32'h0);
      chk("rst_grant",     32'(grant),     32'h0);
      chk("rst_in_ready",  32'(in_ready),  32'h0);
      chk("rst_busy",      32'(busy),      32'h0);
      chk("rst_underflow", 32'(underflow), 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Test 1: requester 0 frame {0xAA, 0x0F last}.
      cyc = 0;
      ticks(90);
      chk("t1_txen_idle", 32'(l_txen[0]), 32'h0);
      for (int i = 1; i <= 40; i++) begin
         chk($sformatf("t1_txen[%0d]", i), 32'(l_txen[i]), 32'h1);
         if (i <= 31)      chk($sformatf("t1_txd[%0d]", i), 32'(l_txd[i]), 32'h1);
         else if (i == 32) chk("t1_sfd", 32'(l_txd[i]), 32'h3);
         else              chk($sformatf("t1_txd[%0d]", i), 32'(l_txd[i]), 32'(pay_exp[i-33]));
      end
      for (int i = 41; i <= 88; i++) chk($sformatf("t1_ifg_txen[%0d]", i), 32'(l_txen[i]), 32'h0);
      for (int i = 0; i <= 89; i++) begin
         chk($sformatf("t1_rdy[%0d]", i), 32'(l_rdy[i]), (i == 32 || i == 36) ? 32'h1 : 32'h0);
         chk($sformatf("t1_uf[%0d]", i), 32'(l_uf[i]), 32'h0);
      end
      chk("t1_grant_first", 32'(l_grant[1]),  32'h1);
      chk("t1_grant_last",  32'(l_grant[40]), 32'h1);
      chk("t1_grant_clear", 32'(l_grant[41]), 32'h0);
      chk("t1_busy_ifg",    32'(l_busy[88]),  32'h1);
      chk("t1_busy_idle",   32'(l_busy[89]),  32'h0);

      // Test 3: requester 1 underflows before its second byte.
      q1.push_back(9'h011);
      q1.push_back(9'h122);
      drive_src();
      cyc = 0;
      ticks(33);
      hold[1] = 1'b1;
      drive_src();
      ticks(5);
      q1.delete();
      hold = '0;
      drive_src();
      ticks(50);
      chk("t3_grant",     32'(l_grant[1]), 32'h2);
      chk("t3_rdy_first", 32'(l_rdy[32]),  32'h2);
      chk("t3_rdy_abort", 32'(l_rdy[36]),  32'h0);
      for (int i = 0; i <= 87; i++)
         chk($sformatf("t3_uf[%0d]", i), 32'(l_uf[i]), (i == 36) ? 32'h1 : 32'h0);
      chk("t3_txen_abort", 32'(l_txen[36]),  32'h1);
      for (int i = 37; i <= 85; i++) chk($sformatf("t3_txen[%0d]", i), 32'(l_txen[i]), 32'h0);
      chk("t3_grant_clear", 32'(l_grant[37]), 32'h0);
      chk("t3_busy_ifg",    32'(l_busy[84]),  32'h1);
      chk("t3_busy_idle",   32'(l_busy[85]),  32'h0);

      // Test 2: both requesters with 1-byte frames, round-robin order.
      q0.push_back(9'h155);
      q0.push_back(9'h155);
      q1.push_back(9'h1A5);
      q1.push_back(9'h1A5);
      drive_src();
      cyc = 0;
      ticks(343);
      for (int k = 0; k < 4; k++)
         chk($sformatf("t2_grant[%0d]", k), 32'(l_grant[1+85*k]), (k % 2 == 1) ? 32'h2 : 32'h1);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("t2_txen_end[%0d]", k),  32'(l_txen[36+85*k]), 32'h1);
         chk($sformatf("t2_txen_fall[%0d]", k), 32'(l_txen[37+85*k]), 32'h0);
         chk($sformatf("t2_txen_gap[%0d]", k),  32'(l_txen[85+85*k]), 32'h0);
         chk($sformatf("t2_txen_rise[%0d]", k), 32'(l_txen[86+85*k]), 32'h1);
      end
      lows = 0;
      for (int i = 37; i <= 85; i++) if (!l_txen[i]) lows++;
      chk("t2_gap_cycles", 32'(lows), 32'd49);
      chk("t2_rdy_req0", 32'(l_rdy[32]),  32'h1);
      chk("t2_rdy_req1", 32'(l_rdy[117]), 32'h2);
      for (int j = 0; j < 4; j++)
         chk($sformatf("t2_a5_txd[%0d]", j), 32'(l_txd[118+j]), 32'(a5_exp[j]));
      chk("t2_busy_end", 32'(l_busy[342]), 32'h0);

      // Test 4: reset asserted mid-payload, then released with req still high.
      q0.push_back(9'h0AA);
      q0.push_back(9'h0BB);
      q0.push_back(9'h1CC);
      drive_src();
      cyc = 0;
      ticks(35);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      ticks(90);
      chk("t4_txen_before", 32'(l_txen[35]),  32'h1);
      chk("t4_txen_reset",  32'(l_txen[36]),  32'h0);
      chk("t4_grant_reset", 32'(l_grant[36]), 32'h0);
      chk("t4_busy_reset",  32'(l_busy[36]),  32'h0);
      chk("t4_txd_reset",   32'(l_txd[36]),   32'h0);
      chk("t4_txen_restart",  32'(l_txen[37]),  32'h1);
      chk("t4_grant_restart", 32'(l_grant[37]), 32'h1);
      chk("t4_rdy_restart",   32'(l_rdy[68]),   32'h1);
      chk("t4_txd_bb",        32'(l_txd[69]),   32'h3);
      chk("t4_busy_end",      32'(l_busy[125]), 32'h0);

      // Test 6: request arriving during IFG waits for IDLE.
      q0.push_back(9'h155);
      drive_src();
      cyc = 0;
      ticks(50);
      q1.push_back(9'h166);
      drive_src();
      ticks(122);
      chk("t6_txen_end",  32'(l_txen[36]), 32'h1);
      for (int i = 37; i <= 85; i++) begin
         chk($sformatf("t6_txen[%0d]", i),  32'(l_txen[i]),  32'h0);
         chk($sformatf("t6_grant[%0d]", i), 32'(l_grant[i]), 32'h0);
      end
      chk("t6_busy_idle",  32'(l_busy[85]),  32'h0);
      chk("t6_txen_rise",  32'(l_txen[86]),  32'h1);
      chk("t6_grant_rise", 32'(l_grant[86]), 32'h2);

`ifdef ETH_TX_ARB_FCS_EN
      // Test 5: FCS over four zero bytes.
      q0.push_back(9'h000);
      q0.push_back(9'h000);
      q0.push_back(9'h000);
      q0.push_back(9'h100);
      drive_src();
      cyc = 0;
      ticks(130);
      c = 32'hFFFFFFFF;
      for (int b = 0; b < 32; b++) c = crc_bit(c, 1'b0);
      fcs = ~c;
      for (int j = 0; j < 16; j++)
         chk($sformatf("t5_fcs[%0d]", j), 32'(l_txd[49+j]), 32'(fcs[2*j +: 2]));
      chk("t5_txen_fcs_end", 32'(l_txen[64]),  32'h1);
      chk("t5_txen_fall",    32'(l_txen[65]),  32'h0);
      chk("t5_grant_fcs",    32'(l_grant[49]), 32'h0);
      c = 32'hFFFFFFFF;
      for (int b = 0; b < 32; b++) c = crc_bit(c, 1'b0);
      for (int j = 0; j < 16; j++) begin
         c = crc_bit(c, l_txd[49+j][0]);
         c = crc_bit(c, l_txd[49+j][1]);
      end
      chk("t5_residue", c, 32'hDEBB20E3);
      chk("t5_busy_end", 32'(l_busy[129]), 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
